lap_sequencer: RTL and testbench
================================

LAP_SEQUENCER -- requirements
Module: lap_sequencer

Interface
REQ-001 Parameter DEB_CYCLES, default 50000: consecutive master_clk cycles of stable synchronized laser_detector level needed to accept a level change.
REQ-002 Parameter LOCKOUT_S, default 5: minimum lap time in whole seconds; beam breaks before it are ignored.
REQ-003 Parameter HOLD_CYCLES, default 150000000: cycles the last lap is shown after a lap completes.
REQ-004 Parameter MAX_MIN, default 99: minutes value at which the run times out.
REQ-005 master_clk  in  1  sole clock; all state changes on its rising edge.
REQ-006 rs_n  in  1  reset, asynchronous assert, active-low.
REQ-007 laser_detector  in  1  asynchronous beam input; 0 = beam broken.
REQ-008 key_start  in  1  asynchronous pushbutton, active-low, debounced like laser_detector.
REQ-009 minutes, seconds, centis  in  7 each  live timer value, binary, 0..99 / 0..59 / 0..99.
REQ-010 timer_en  out  1  count enable to the lap timer.
REQ-011 timer_clr  out  1  one-cycle synchronous clear pulse to the lap timer.
REQ-012 lap_min, lap_sec, lap_cs  out  7 each  last captured lap time.
REQ-013 best_min, best_sec, best_cs  out  7 each  fastest lap since start.
REQ-014 lap_count  out  7  completed laps, saturating at 99.
REQ-015 lap_valid  out  1  one-cycle pulse when a lap is captured.
REQ-016 disp_sel  out  2  display source: 0 live, 1 last lap, 2 best.
REQ-017 timeout  out  1  sticky flag: run ended by MAX_MIN.

Function
REQ-018 Each asynchronous input passes a 2-flop synchronizer, then a debouncer that changes its output only after DEB_CYCLES identical samples; input-to-output latency is 2+DEB_CYCLES cycles.
REQ-019 A break event is a single-cycle pulse on the debounced laser 1->0 transition; a key event is a single-cycle pulse on the debounced key 1->0 transition.
REQ-020 FSM states: IDLE, ARMED, RUNNING, HOLD.
REQ-021 IDLE: timer_en=0, disp_sel=2; a key event clears lap_count, best-valid and timeout, then the FSM moves to ARMED.
REQ-022 ARMED: timer_en=0, disp_sel=0; a break event asserts timer_clr for that cycle, then the FSM moves to RUNNING.
REQ-023 RUNNING: timer_en=1, disp_sel=0.
REQ-024 In RUNNING, a break event is accepted only if minutes!=0 or seconds>=LOCKOUT_S; otherwise it is ignored with no output change.
REQ-025 An accepted break event has the following effects in the same cycle: it captures {minutes,seconds,centis} into lap_*, pulses lap_valid and timer_clr, increments lap_count (saturating at 99), loads the hold counter with HOLD_CYCLES-1, and the FSM moves to HOLD.
REQ-026 Best update: the captured lap is copied to best_* if best is not valid or if {min,sec,cs} compares lexicographically below best; equal times do not update; best becomes valid.
REQ-027 HOLD: timer_en=1, disp_sel=1; the hold counter decrements each cycle, and at 0 the FSM returns to RUNNING.
REQ-028 A break event in HOLD follows the same lockout and capture rules as in RUNNING (REQ-024..026) and reloads the hold counter.
REQ-029 A key event in ARMED, RUNNING or HOLD moves the FSM to IDLE with timer_en=0; lap and best registers are retained.
REQ-030 Timeout: in RUNNING or HOLD, minutes>=MAX_MIN sets timeout and moves the FSM to IDLE; timeout has priority over a same-cycle break event.
REQ-031 A key event has priority over a same-cycle break event in all states.
REQ-032 timer_clr is never asserted for more than one consecutive cycle.

Reset
REQ-033 While rs_n=0, all of the following hold: FSM=IDLE; timer_en, timer_clr, lap_valid, timeout=0; lap_*, best_*, lap_count=0; best-valid=0; disp_sel=2; synchronizer and debouncer outputs=1 (idle level).
REQ-034 Reset deassertion mid-run leaves the design in IDLE; no event is generated by the release itself.

Structure
REQ-035 A shared package holds the FSM state encoding, the disp_sel codes (LIVE, LAST, BEST), and the time-field width constant (7).
REQ-036 One sub-module, sync_debounce (parameter DEB_CYCLES, 1-bit in/out), is instantiated twice, once for laser_detector and once for key_start.

Verification
REQ-037 Scenario 1, basic run: with DEB_CYCLES=4, press key, then break beam → ARMED, then timer_clr pulse, then timer_en=1.
REQ-038 Scenario 2, lockout: break at seconds=3 → ignored; break at 0:07:42 → lap_* = 0:07:42, lap_count=1, best = 0:07:42.
REQ-039 Scenario 3, best-lap compare: laps 0:07:42 then 0:06:99 → best becomes 0:06:99; a further lap of 0:06:99 → best unchanged, lap_count=3.
REQ-040 Scenario 4, debounce: a 3-cycle glitch with DEB_CYCLES=4 → no event; a 4-cycle break → exactly one event.
REQ-041 Scenario 5, timeout and priority: minutes=99 → IDLE with timeout=1; a simultaneous key and break event → IDLE with no lap captured.
REQ-042 Scenario 6, reset mid-run: rs_n low during HOLD → all outputs at reset values immediately, without waiting for a master_clk edge.

Source files
------------

// File: rtl/lap_sequencer_pkg.sv
// Shared definitions for the lap sequencer: FSM encoding, display source
// codes, time field width and the lap-time ordering helper.
package lap_sequencer_pkg;

    localparam int TIME_W = 7;

    localparam logic [TIME_W-1:0] LAP_COUNT_MAX = 7'd99;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        RUNNING = 2'd2,
        HOLD    = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        DISP_LIVE = 2'd0,
        DISP_LAST = 2'd1,
        DISP_BEST = 2'd2
    } disp_t;

    // Fields are ordered most-significant first, so a plain numeric compare
    // of the packed struct is the lexicographic {min,sec,cs} ordering.
    typedef struct packed {
        logic [TIME_W-1:0] min;
        logic [TIME_W-1:0] sec;
        logic [TIME_W-1:0] cs;
    } lap_time_t;

    function automatic logic time_less(input lap_time_t a, input lap_time_t b);
        return a < b;
    endfunction

endpackage

// File: rtl/lap_sequencer_sync.sv
// Two-flop synchronizer followed by a counting debouncer. The output only
// follows the synchronized input after DEB_CYCLES identical samples; both
// stages idle high.
module sync_debounce #(
    parameter int DEB_CYCLES = 50000
) (
    input  logic master_clk,
    input  logic rs_n,
    input  logic raw,
    output logic level
);

    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          sync_a;
    logic          sync_b;
    logic [CW-1:0] stable_cnt;

    // Bring the asynchronous input into the master_clk domain.
    always_ff @(posedge master_clk or negedge rs_n) begin
        if (!rs_n) begin
            sync_a <= 1'b1;
            sync_b <= 1'b1;
        end else begin
            sync_a <= raw;
            sync_b <= sync_a;
        end
    end

    // Accept a new level once it has been seen DEB_CYCLES times in a row.
    always_ff @(posedge master_clk or negedge rs_n) begin
        if (!rs_n) begin
            level      <= 1'b1;
            stable_cnt <= '0;
        end else if (sync_b == level) begin
            stable_cnt <= '0;
        end else if (stable_cnt == CNT_LAST) begin
            level      <= sync_b;
            stable_cnt <= '0;
        end else begin
            stable_cnt <= stable_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/lap_sequencer.sv
// Lap sequencer: turns debounced beam breaks and start-key presses into lap
// timer control, captures lap times, tracks the best lap and the lap count.
module lap_sequencer
    import lap_sequencer_pkg::*;
#(
    parameter int DEB_CYCLES  = 50000,
    parameter int LOCKOUT_S   = 5,
    parameter int HOLD_CYCLES = 150000000,
    parameter int MAX_MIN     = 99
) (
    input  logic              master_clk,
    input  logic              rs_n,
    input  logic              laser_detector,
    input  logic              key_start,
    input  logic [TIME_W-1:0] minutes,
    input  logic [TIME_W-1:0] seconds,
    input  logic [TIME_W-1:0] centis,
    output logic              timer_en,
    output logic              timer_clr,
    output logic [TIME_W-1:0] lap_min,
    output logic [TIME_W-1:0] lap_sec,
    output logic [TIME_W-1:0] lap_cs,
    output logic [TIME_W-1:0] best_min,
    output logic [TIME_W-1:0] best_sec,
    output logic [TIME_W-1:0] best_cs,
    output logic [TIME_W-1:0] lap_count,
    output logic              lap_valid,
    output logic [1:0]        disp_sel,
    output logic              timeout
);

    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);

    logic      laser_level;
    logic      key_level;
    logic      laser_prev;
    logic      key_prev;
    logic      brk_ev;
    logic      key_ev;
    state_t    state;
    state_t    next_state;
    logic      in_run;
    logic      timed_out;
    logic      lock_ok;
    logic      accept;
    logic      best_valid;
    logic [HW-1:0] hold_cnt;
    logic      hold_done;
    lap_time_t live_time;
    lap_time_t best_time;

    sync_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_laser_db (
        .master_clk (master_clk),
        .rs_n       (rs_n),
        .raw        (laser_detector),
        .level      (laser_level)
    );

    sync_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_key_db (
        .master_clk (master_clk),
        .rs_n       (rs_n),
        .raw        (key_start),
        .level      (key_level)
    );

    // Remember last debounced levels so falling edges become one-cycle events.
    always_ff @(posedge master_clk or negedge rs_n) begin
        if (!rs_n) begin
            laser_prev <= 1'b1;
            key_prev   <= 1'b1;
        end else begin
            laser_prev <= laser_level;
            key_prev   <= key_level;
        end
    end

    assign brk_ev    = laser_prev & ~laser_level;
    assign key_ev    = key_prev & ~key_level;
    assign in_run    = (state == RUNNING) || (state == HOLD);
    assign timed_out = in_run && (minutes >= TIME_W'(MAX_MIN));
    assign lock_ok   = (minutes != '0) || (seconds >= TIME_W'(LOCKOUT_S));
    assign accept    = in_run && brk_ev && !key_ev && !timed_out && lock_ok;
    assign hold_done = (hold_cnt == '0);
    assign live_time = '{minutes, seconds, centis};
    assign best_time = '{best_min, best_sec, best_cs};

    // FSM state register.
    always_ff @(posedge master_clk or negedge rs_n) begin
        if (!rs_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state selection; key beats timeout, timeout beats a lap capture.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (key_ev) next_state = ARMED;
            end
            ARMED: begin
                if (key_ev)      next_state = IDLE;
                else if (brk_ev) next_state = RUNNING;
            end
            RUNNING, HOLD: begin
                if (key_ev || timed_out)             next_state = IDLE;
                else if (accept)                     next_state = HOLD;
                else if (state == HOLD && hold_done) next_state = RUNNING;
            end
            default: next_state = IDLE;
        endcase
    end

    // Timer control, display source and capture pulse for the current state.
    always_comb begin
        timer_en = 1'b0;
        disp_sel = DISP_BEST;
        case (state)
            ARMED:   disp_sel = DISP_LIVE;
            RUNNING: begin
                timer_en = 1'b1;
                disp_sel = DISP_LIVE;
            end
            HOLD:    begin
                timer_en = 1'b1;
                disp_sel = DISP_LAST;
            end
            default: ;
        endcase
        timer_clr = ((state == ARMED) && brk_ev && !key_ev) || accept;
        lap_valid = accept;
    end

    // Lap capture, best-lap tracking, lap count, timeout flag and hold timer.
    always_ff @(posedge master_clk or negedge rs_n) begin
        if (!rs_n) begin
            lap_min    <= '0;
            lap_sec    <= '0;
            lap_cs     <= '0;
            best_min   <= '0;
            best_sec   <= '0;
            best_cs    <= '0;
            best_valid <= 1'b0;
            lap_count  <= '0;
            timeout    <= 1'b0;
            hold_cnt   <= '0;
        end else begin
            if (state == IDLE && key_ev) begin
                lap_count  <= '0;
                best_valid <= 1'b0;
                timeout    <= 1'b0;
            end
            if (timed_out) begin
                timeout <= 1'b1;
            end
            if (accept) begin
                lap_min <= minutes;
                lap_sec <= seconds;
                lap_cs  <= centis;
                if (lap_count != LAP_COUNT_MAX) begin
                    lap_count <= lap_count + 7'd1;
                end
                if (!best_valid || time_less(live_time, best_time)) begin
                    best_min <= minutes;
                    best_sec <= seconds;
                    best_cs  <= centis;
                end
                best_valid <= 1'b1;
                hold_cnt   <= HOLD_LOAD;
            end else if (state == HOLD && !hold_done) begin
                hold_cnt <= hold_cnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_lap_sequencer.sv
// Self-checking bench for lap_sequencer: directed scenarios with literal
// expectations plus a randomized phase, all checked every cycle against a
// behavioural model of the lap rules.
module tb_lap_sequencer;

    localparam int DEB   = 4;
    localparam int LOCK  = 5;
    localparam int HOLDC = 20;
    localparam int MAXM  = 99;

    localparam int M_IDLE  = 0;
    localparam int M_ARMED = 1;
    localparam int M_RUN   = 2;
    localparam int M_HOLD  = 3;

    logic       master_clk = 1'b0;
    logic       rs_n = 1'b0;
    logic       laser_detector = 1'b1;
    logic       key_start = 1'b1;
    logic [6:0] minutes = '0;
    logic [6:0] seconds = '0;
    logic [6:0] centis = '0;
    logic       timer_en, timer_clr, lap_valid, timeout;
    logic [6:0] lap_min, lap_sec, lap_cs, best_min, best_sec, best_cs, lap_count;
    logic [1:0] disp_sel;

    int total = 0;
    int bad = 0;
    int lv_seen = 0;
    int clr_seen = 0;

    int m_mode, m_lap, m_best, m_bestv, m_cnt, m_tmo, m_hold;
    logic [DEB+1:0] h_laser, h_key;
    logic db_laser, db_key, ev_laser, ev_key;

    always #5 master_clk = ~master_clk;

    lap_sequencer #(
        .DEB_CYCLES  (DEB),
        .LOCKOUT_S   (LOCK),
        .HOLD_CYCLES (HOLDC),
        .MAX_MIN     (MAXM)
    ) dut (
        .master_clk     (master_clk),
        .rs_n           (rs_n),
        .laser_detector (laser_detector),
        .key_start      (key_start),
        .minutes        (minutes),
        .seconds        (seconds),
        .centis         (centis),
        .timer_en       (timer_en),
        .timer_clr      (timer_clr),
        .lap_min        (lap_min),
        .lap_sec        (lap_sec),
        .lap_cs         (lap_cs),
        .best_min       (best_min),
        .best_sec       (best_sec),
        .best_cs        (best_cs),
        .lap_count      (lap_count),
        .lap_valid      (lap_valid),
        .disp_sel       (disp_sel),
        .timeout        (timeout)
    );

    task automatic checkOutput(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, wanted %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        m_mode = M_IDLE; m_lap = 0; m_best = 0; m_bestv = 0;
        m_cnt = 0; m_tmo = 0; m_hold = 0;
        h_laser = '1; h_key = '1;
        db_laser = 1'b1; db_key = 1'b1; ev_laser = 1'b0; ev_key = 1'b0;
    endtask

    // A level is accepted once the last DEB samples, seen two cycles late,
    // all disagree with it; the event is the accepted 1->0 change.
    task automatic debStep(input logic raw, inout logic [DEB+1:0] h,
                           inout logic db, output logic ev);
        logic [DEB-1:0] win;
        logic old;
        h   = {h[DEB:0], raw};
        win = h[DEB+1:2];
        old = db;
        if (db && win == '0) db = 1'b0;
        else if (!db && win == '1) db = 1'b1;
        ev = old && !db;
    endtask

    // Per-cycle compare against the model, then advance the model one edge.
    initial begin
        logic prev_clr;
        logic brk, key, runhold, to, lock, acc, exp_clr;
        int   live, exp_disp;
        prev_clr = 1'b0;
        modelReset();
        forever begin
            @(negedge master_clk);
            #1;
            if (!rs_n) begin
                modelReset();
                prev_clr = 1'b0;
            end else begin
                brk     = ev_laser;
                key     = ev_key;
                runhold = (m_mode == M_RUN) || (m_mode == M_HOLD);
                to      = runhold && (minutes >= MAXM);
                lock    = (minutes != 0) || (seconds >= LOCK);
                acc     = runhold && brk && !key && !to && lock;
                exp_clr = ((m_mode == M_ARMED) && brk && !key) || acc;
                exp_disp = (m_mode == M_IDLE) ? 2 : (m_mode == M_HOLD) ? 1 : 0;
                live    = minutes * 10000 + seconds * 100 + centis;

                checkOutput("timer_en", timer_en, runhold);
                checkOutput("disp_sel", disp_sel, exp_disp);
                checkOutput("timer_clr", timer_clr, exp_clr);
                checkOutput("lap_valid", lap_valid, acc);
                checkOutput("timeout", timeout, m_tmo);
                checkOutput("lap_count", lap_count, m_cnt);
                checkOutput("lap_min", lap_min, m_lap / 10000);
                checkOutput("lap_sec", lap_sec, (m_lap / 100) % 100);
                checkOutput("lap_cs", lap_cs, m_lap % 100);
                checkOutput("best_min", best_min, m_best / 10000);
                checkOutput("best_sec", best_sec, (m_best / 100) % 100);
                checkOutput("best_cs", best_cs, m_best % 100);
                checkOutput("clr_double", int'(prev_clr && timer_clr), 0);
                prev_clr = timer_clr;
                if (lap_valid) lv_seen++;
                if (timer_clr) clr_seen++;

                case (m_mode)
                    M_IDLE: if (key) begin
                        m_cnt = 0; m_bestv = 0; m_tmo = 0; m_mode = M_ARMED;
                    end
                    M_ARMED: begin
                        if (key) m_mode = M_IDLE;
                        else if (brk) m_mode = M_RUN;
                    end
                    default: begin
                        if (to) m_tmo = 1;
                        if (key || to) m_mode = M_IDLE;
                        else if (acc) begin
                            m_lap = live;
                            if (m_cnt < 99) m_cnt++;
                            if (!m_bestv || live < m_best) m_best = live;
                            m_bestv = 1;
                            m_hold = HOLDC - 1;
                            m_mode = M_HOLD;
                        end else if (m_mode == M_HOLD) begin
                            if (m_hold == 0) m_mode = M_RUN;
                            else m_hold--;
                        end
                    end
                endcase
                debStep(laser_detector, h_laser, db_laser, ev_laser);
                debStep(key_start, h_key, db_key, ev_key);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge master_clk);
            #2;
        end
    endtask

    task automatic applyStimulus(input int m, input int s, input int c);
        minutes = 7'(m);
        seconds = 7'(s);
        centis  = 7'(c);
    endtask

    task automatic breakBeam(input int len);
        laser_detector = 1'b0;
        tick(len);
        laser_detector = 1'b1;
        tick(DEB + 6);
    endtask

    task automatic pressKey(input int len);
        key_start = 1'b0;
        tick(len);
        key_start = 1'b1;
        tick(DEB + 6);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got no finish, wanted finish before 1ms");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base;
        int r;

        // Reset values
        rs_n = 1'b0;
        tick(3);
        checkOutput("rst_disp", disp_sel, 2);
        checkOutput("rst_en", timer_en, 0);
        checkOutput("rst_cnt", lap_count, 0);
        checkOutput("rst_tmo", timeout, 0);
        rs_n = 1'b1;
        tick(2);

        // Basic run: key arms, first break clears and starts the timer
        pressKey(6);
        checkOutput("arm_disp", disp_sel, 0);
        checkOutput("arm_en", timer_en, 0);
        base = clr_seen;
        breakBeam(6);
        checkOutput("start_clr", clr_seen - base, 1);
        checkOutput("run_en", timer_en, 1);

        // Lockout, then a first accepted lap
        applyStimulus(0, 3, 10);
        base = lv_seen;
        breakBeam(6);
        checkOutput("lock_lv", lv_seen - base, 0);
        checkOutput("lock_cnt", lap_count, 0);
        applyStimulus(0, 7, 42);
        breakBeam(6);
        checkOutput("lap1_min", lap_min, 0);
        checkOutput("lap1_sec", lap_sec, 7);
        checkOutput("lap1_cs", lap_cs, 42);
        checkOutput("lap1_cnt", lap_count, 1);
        checkOutput("best1_sec", best_sec, 7);
        checkOutput("best1_cs", best_cs, 42);
        checkOutput("hold_disp", disp_sel, 1);
        tick(25);
        checkOutput("run_disp", disp_sel, 0);

        // Best-lap compare: faster lap wins, equal lap leaves best alone
        applyStimulus(0, 6, 99);
        breakBeam(6);
        checkOutput("best2_sec", best_sec, 6);
        checkOutput("best2_cs", best_cs, 99);
        checkOutput("lap2_cnt", lap_count, 2);
        tick(25);
        breakBeam(6);
        checkOutput("best3_sec", best_sec, 6);
        checkOutput("best3_cs", best_cs, 99);
        checkOutput("lap3_cnt", lap_count, 3);
        tick(25);

        // Debounce: 3-cycle glitch ignored, 4-cycle break is one event
        base = lv_seen;
        breakBeam(3);
        checkOutput("glitch_lv", lv_seen - base, 0);
        applyStimulus(0, 8, 0);
        breakBeam(4);
        checkOutput("deb_lv", lv_seen - base, 1);
        checkOutput("deb_cnt", lap_count, 4);
        tick(25);

        // Timeout ends the run
        applyStimulus(99, 0, 0);
        tick(3);
        checkOutput("to_flag", timeout, 1);
        checkOutput("to_disp", disp_sel, 2);
        checkOutput("to_en", timer_en, 0);
        applyStimulus(0, 0, 0);

        // Restart clears timeout; simultaneous key and break captures nothing
        pressKey(6);
        checkOutput("restart_tmo", timeout, 0);
        checkOutput("restart_cnt", lap_count, 0);
        breakBeam(6);
        applyStimulus(0, 9, 0);
        base = lv_seen;
        laser_detector = 1'b0;
        key_start = 1'b0;
        tick(6);
        laser_detector = 1'b1;
        key_start = 1'b1;
        tick(10);
        checkOutput("both_disp", disp_sel, 2);
        checkOutput("both_lv", lv_seen - base, 0);

        // Reset during HOLD acts without waiting for a clock edge
        pressKey(6);
        breakBeam(6);
        applyStimulus(0, 7, 0);
        breakBeam(6);
        checkOutput("prerst_disp", disp_sel, 1);
        rs_n = 1'b0;
        #1;
        checkOutput("async_disp", disp_sel, 2);
        checkOutput("async_en", timer_en, 0);
        checkOutput("async_cnt", lap_count, 0);
        checkOutput("async_lap", lap_sec, 0);
        checkOutput("async_best", best_sec, 0);
        tick(2);
        rs_n = 1'b1;
        tick(4);
        checkOutput("release_disp", disp_sel, 2);

        // Randomized phase
        pressKey(6);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 11) == 0) laser_detector = ~laser_detector;
            if ($urandom_range(0, 199) == 0) key_start = ~key_start;
            r = $urandom_range(0, 499);
            applyStimulus((r == 0) ? 99 : (r < 80) ? int'($urandom_range(1, 3)) : 0,
                          $urandom_range(0, 59), $urandom_range(0, 99));
            tick(1);
        end
        laser_detector = 1'b1;
        key_start = 1'b1;
        tick(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
